// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding, instruction format/condition codes and PC width
package fetch_unit_pkg;
    localparam int PC_W = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_UPDATE
    } state_t;
    localparam logic [1:0] FMT_REG = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;
    localparam logic [1:0] FMT_BR  = 2'b10;
    typedef enum logic [1:0] {
        C_EQ = 2'b00,
        C_GT = 2'b01,
        C_LT = 2'b10,
        C_AL = 2'b11
    } cond_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory, control-FSM handshake and status signals of the fetch unit
interface fetch_unit_if;
    import fetch_unit_pkg::*;
    logic            start;
    logic [PC_W-1:0] mem_addr;
    logic            mem_rd;
    logic [15:0]     mem_data;
    logic [15:0]     d_inst;
    logic            run;
    logic            done;
    logic [2:0]      flags;
    logic [PC_W-1:0] pc;
    logic            busy;
    modport master (
        input  start, mem_data, done, flags,
        output mem_addr, mem_rd, d_inst, run, pc, busy
    );
    modport slave (
        output start, mem_data, done, flags,
        input  mem_addr, mem_rd, d_inst, run, pc, busy
    );
endinterface

// File: rtl/fetch_unit_branch_eval.sv
// branch_eval: resolves a branch condition code against latched {lt, gt, eq} flags
module branch_eval
    import fetch_unit_pkg::*;
(
    input  logic [1:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);
    always_comb begin
        taken = (cond == C_EQ) ? flags[0] :
                (cond == C_GT) ? flags[1] :
                (cond == C_LT) ? flags[2] : 1'b1;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches an instruction, hands it to the control FSM, waits for done
// and advances or branches the program counter.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    state_t          state;
    logic [2:0]      flags_q;
    logic            taken;
    logic [PC_W-1:0] next_pc;

    branch_eval u_branch_eval (
        .cond  (bus.d_inst[3:2]),
        .flags (flags_q),
        .taken (taken)
    );

    assign next_pc = (bus.d_inst[1:0] == FMT_BR && taken) ? bus.d_inst[11:4] : bus.pc + 8'd1;

    // outputs are registered alongside the state so they always match the state just entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bus.pc       <= '0;
            bus.d_inst   <= '0;
            bus.run      <= 1'b0;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= '0;
            bus.busy     <= 1'b0;
            flags_q      <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state        <= S_FETCH;
                    bus.mem_rd   <= 1'b1;
                    bus.mem_addr <= bus.pc;
                    bus.busy     <= 1'b1;
                end
                S_FETCH: begin
                    bus.mem_rd <= 1'b0;
                    state      <= S_LOAD;
                end
                S_LOAD: begin
                    bus.d_inst <= bus.mem_data;
                    bus.run    <= 1'b1;
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    bus.run <= 1'b0;
                    state   <= S_WAIT;
                end
                S_WAIT: if (bus.done) begin
                    flags_q <= bus.flags;
                    state   <= S_UPDATE;
                end
                S_UPDATE: begin
                    bus.pc       <= next_pc;
                    bus.mem_addr <= next_pc;
                    bus.mem_rd   <= bus.start;
                    bus.busy     <= bus.start;
                    state        <= bus.start ? S_FETCH : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand-written corner sequences and a randomized
// program run checked against a spec-level next-pc model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    fetch_unit_if bus();
    fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] inst;
        logic [2:0]  fl;
        int          dly;
        logic [7:0]  want;
    } vec_t;

    vec_t        vecs [12];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_pc;
    logic [15:0] mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [7:0] model_pc(input logic [15:0] inst, input logic [2:0] fl, input logic [7:0] pc);
        int  c;
        bit  take;
        logic [7:0] inc;
        inc = 8'((int'(pc) + 1) % 256);
        if (inst[1:0] != 2'b10) return inc;
        c = int'(inst[3:2]);
        if (c == 0) take = fl[0];
        else if (c == 1) take = fl[1];
        else if (c == 2) take = fl[2];
        else take = 1'b1;
        return take ? inst[11:4] : inc;
    endfunction

    // entered at the negedge of a FETCH cycle, leaves at the negedge after UPDATE
    task automatic do_instr(input logic [15:0] inst, input logic [2:0] fl, input int dly,
                            input bit keep, input bit spur, input logic [7:0] want);
        chk("fetch_rd", bus.mem_rd, 1);
        chk("fetch_addr", bus.mem_addr, exp_pc);
        chk("fetch_run", bus.run, 0);
        chk("fetch_busy", bus.busy, 1);
        bus.mem_data = ~inst;
        bus.done = spur;
        bus.flags = 3'($urandom);
        @(negedge clk);
        chk("load_rd", bus.mem_rd, 0);
        chk("load_run", bus.run, 0);
        bus.mem_data = inst;
        bus.done = 1'b0;
        @(negedge clk);
        chk("issue_run", bus.run, 1);
        chk("issue_rd", bus.mem_rd, 0);
        chk("issue_inst", bus.d_inst, inst);
        bus.mem_data = 16'($urandom);
        for (int k = 0; k <= dly; k++) begin
            @(negedge clk);
            chk("wait_run", bus.run, 0);
            chk("wait_rd", bus.mem_rd, 0);
            chk("wait_inst", bus.d_inst, inst);
            chk("wait_pc", bus.pc, exp_pc);
            if (!keep) bus.start = 1'b0;
            bus.done = (k == dly);
            bus.flags = (k == dly) ? fl : 3'($urandom);
        end
        @(negedge clk);
        chk("update_busy", bus.busy, 1);
        chk("update_run", bus.run, 0);
        chk("update_inst", bus.d_inst, inst);
        bus.done = 1'b0;
        bus.flags = 3'($urandom);
        @(negedge clk);
        chk("next_pc", bus.pc, want);
        chk("next_busy", bus.busy, keep);
        chk("next_rd", bus.mem_rd, keep);
        exp_pc = want;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{16'h2001, 3'b000, 2, 8'h01},
            '{16'h0A02, 3'b001, 0, 8'hA0},
            '{16'h0A02, 3'b010, 1, 8'hA1},
            '{16'h0F0E, 3'b000, 0, 8'hF0},
            '{16'h010A, 3'b100, 3, 8'h10},
            '{16'h099A, 3'b011, 0, 8'h11},
            '{16'h0556, 3'b010, 1, 8'h55},
            '{16'h0772, 3'b110, 0, 8'h56},
            '{16'h1234, 3'b111, 2, 8'h57},
            '{16'h0FF3, 3'b001, 0, 8'h58},
            '{16'h0FFE, 3'b000, 0, 8'hFF},
            '{16'h0001, 3'b001, 1, 8'h00}
        };
        reset = 1'b1;
        bus.start = 1'b0;
        bus.done = 1'b0;
        bus.flags = '0;
        bus.mem_data = '0;
        exp_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", bus.pc, 0);
        chk("rst_inst", bus.d_inst, 0);
        chk("rst_run", bus.run, 0);
        chk("rst_rd", bus.mem_rd, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_rd", bus.mem_rd, 0);
        bus.start = 1'b1;
        @(negedge clk);
        foreach (vecs[i]) do_instr(vecs[i].inst, vecs[i].fl, vecs[i].dly, 1'b1, 1'b0, vecs[i].want);

        // start dropped during WAIT, done pulsed during FETCH
        do_instr(16'h3005, 3'b000, 1, 1'b0, 1'b1, 8'h01);
        repeat (3) begin
            @(negedge clk);
            chk("stop_busy", bus.busy, 0);
            chk("stop_rd", bus.mem_rd, 0);
            chk("stop_pc", bus.pc, 1);
        end

        // reset during WAIT followed by a stray done
        bus.start = 1'b1;
        @(negedge clk);
        chk("rw_fetch_rd", bus.mem_rd, 1);
        @(negedge clk);
        bus.mem_data = 16'h0FFE;
        @(negedge clk);
        chk("rw_issue_run", bus.run, 1);
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus.done = 1'b1;
        bus.flags = 3'b111;
        @(negedge clk);
        bus.done = 1'b0;
        repeat (4) begin
            chk("rw_run", bus.run, 0);
            chk("rw_rd", bus.mem_rd, 0);
            chk("rw_busy", bus.busy, 0);
            chk("rw_pc", bus.pc, 0);
            chk("rw_inst", bus.d_inst, 0);
            @(negedge clk);
        end

        // randomized program against the reference model
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b10;
        end
        exp_pc = '0;
        bus.start = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            logic [15:0] inst;
            logic [2:0]  fl;
            bit          keep;
            inst = mem[exp_pc];
            fl = 3'($urandom);
            keep = ($urandom_range(0, 5) != 0);
            do_instr(inst, fl, int'($urandom_range(0, 3)), keep, 1'($urandom), model_pc(inst, fl, exp_pc));
            if (!keep) begin
                @(negedge clk);
                chk("rnd_idle_busy", bus.busy, 0);
                bus.start = 1'b1;
                @(negedge clk);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
